// File: rtl/fp_pkg.sv
// Shared floating-point definitions: IEEE-754 single field layout, exponent
// constants and the fp->int converter state encoding.
package fp_pkg;

   localparam int          FP_EXP_BIAS = 127;
   localparam int          FP_MANT_W   = 23;
   localparam logic [7:0]  FP_EXP_INF  = 8'hFF;

   // -2^31 is the only value with exponent 158 that still fits in int32.
   localparam logic [31:0] FP_INT_MIN_BITS = 32'hCF00_0000;

   typedef struct packed {
      logic       sign;
      logic [7:0] exp;
      logic [22:0] frac;
   } fp32_t;

   typedef enum logic [2:0] {
      IDLE,
      DECODE,
      ALIGN,
      SIGN,
      DONE
   } f2i_state_t;

endpackage

// File: rtl/fp_classify.sv
// Combinational classifier for an fp32 operand headed to the integer domain:
// special-case flags plus the shift distance/direction that aligns the mantissa.
module fp_classify
   import fp_pkg::*;
(
   input  fp32_t      i_op,
   output logic       o_is_nan,
   output logic       o_is_inf,
   output logic       o_is_zero_or_denorm,
   output logic       o_is_underflow,
   output logic       o_is_overflow,
   output logic       o_is_min_int,
   output logic       o_shift_left,
   output logic [7:0] o_shift_cnt
);

   // Exponent where the mantissa LSB has weight 1, and where |value| reaches 2^31.
   localparam logic [7:0] EXP_UNITY   = 8'(FP_EXP_BIAS);
   localparam logic [7:0] EXP_INT_LSB = 8'(FP_EXP_BIAS + FP_MANT_W);
   localparam logic [7:0] EXP_SAT     = 8'(FP_EXP_BIAS + 31);

   logic w_exp_max;

   assign w_exp_max           = (i_op.exp == FP_EXP_INF);
   assign o_is_nan            = w_exp_max && (i_op.frac != '0);
   assign o_is_inf            = w_exp_max && (i_op.frac == '0);
   assign o_is_zero_or_denorm = (i_op.exp == 8'h00);
   assign o_is_underflow      = (i_op.exp < EXP_UNITY);
   assign o_is_min_int        = (i_op == FP_INT_MIN_BITS);
   assign o_is_overflow       = (i_op.exp >= EXP_SAT) && !o_is_min_int;

   assign o_shift_left = (i_op.exp >= EXP_INT_LSB);
   assign o_shift_cnt  = o_shift_left ? (i_op.exp - EXP_INT_LSB)
                                      : (EXP_INT_LSB - i_op.exp);

endmodule

// File: rtl/fp_to_int.sv
// Multi-cycle fp32 -> int32 converter (truncate toward zero, saturating).
// The mantissa is aligned SHIFT_STEP bits per cycle; right shifts collect a sticky bit.
module fp_to_int
   import fp_pkg::*;
#(
   parameter int          SHIFT_STEP = 4,
   parameter logic [31:0] NAN_RESULT = 32'h7FFF_FFFF
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic [31:0] op,
   output logic        busy,
   output logic [31:0] int_result,
   output logic        conv_done,
   output logic        conv_overflow,
   output logic        conv_inexact
);

   localparam logic [7:0] STEP = 8'(SHIFT_STEP);

   f2i_state_t  r_state;
   fp32_t       r_op;
   logic [31:0] r_mag;
   logic [7:0]  r_cnt;
   logic        r_left;
   logic        r_sticky;

   logic        w_is_nan;
   logic        w_is_inf;
   logic        w_is_zod;
   logic        w_is_underflow;
   logic        w_is_overflow;
   logic        w_is_min_int;
   logic        w_shift_left;
   logic [7:0]  w_shift_cnt;
   logic [7:0]  w_step;
   logic [31:0] w_lost;
   logic [31:0] w_sat;

   fp_classify u_classify (
      .i_op                (r_op),
      .o_is_nan            (w_is_nan),
      .o_is_inf            (w_is_inf),
      .o_is_zero_or_denorm (w_is_zod),
      .o_is_underflow      (w_is_underflow),
      .o_is_overflow       (w_is_overflow),
      .o_is_min_int        (w_is_min_int),
      .o_shift_left        (w_shift_left),
      .o_shift_cnt         (w_shift_cnt)
   );

   assign w_step = (r_cnt > STEP) ? STEP : r_cnt;
   // Bits about to fall off the bottom on this right-shift step.
   assign w_lost = r_left ? 32'h0 : (r_mag & ((32'h1 << w_step) - 32'h1));
   assign w_sat  = r_op.sign ? 32'h8000_0000 : 32'h7FFF_FFFF;

   assign busy      = (r_state != IDLE);
   assign conv_done = (r_state == DONE);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state       <= IDLE;
         r_op          <= '0;
         r_mag         <= '0;
         r_cnt         <= '0;
         r_left        <= 1'b0;
         r_sticky      <= 1'b0;
         int_result    <= '0;
         conv_overflow <= 1'b0;
         conv_inexact  <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               if (start) begin
                  r_op    <= op;
                  r_state <= DECODE;
               end
            end
            DECODE: begin
               if (w_is_nan) begin
                  int_result    <= NAN_RESULT;
                  conv_overflow <= 1'b1;
                  conv_inexact  <= 1'b0;
                  r_state       <= DONE;
               end else if (w_is_inf) begin
                  int_result    <= w_sat;
                  conv_overflow <= 1'b1;
                  conv_inexact  <= 1'b0;
                  r_state       <= DONE;
               end else if (w_is_underflow) begin
                  int_result    <= '0;
                  conv_overflow <= 1'b0;
                  conv_inexact  <= !w_is_zod || (r_op.frac != '0);
                  r_state       <= DONE;
               end else if (w_is_min_int) begin
                  int_result    <= 32'h8000_0000;
                  conv_overflow <= 1'b0;
                  conv_inexact  <= 1'b0;
                  r_state       <= DONE;
               end else if (w_is_overflow) begin
                  int_result    <= w_sat;
                  conv_overflow <= 1'b1;
                  conv_inexact  <= 1'b0;
                  r_state       <= DONE;
               end else begin
                  r_mag    <= {8'h00, 1'b1, r_op.frac};
                  r_cnt    <= w_shift_cnt;
                  r_left   <= w_shift_left;
                  r_sticky <= 1'b0;
                  r_state  <= (w_shift_cnt != 8'd0) ? ALIGN : SIGN;
               end
            end
            ALIGN: begin
               r_mag    <= r_left ? (r_mag << w_step) : (r_mag >> w_step);
               r_sticky <= r_sticky | (|w_lost);
               r_cnt    <= r_cnt - w_step;
               if (r_cnt == w_step) r_state <= SIGN;
            end
            SIGN: begin
               int_result    <= r_op.sign ? (32'h0 - r_mag) : r_mag;
               conv_overflow <= 1'b0;
               conv_inexact  <= r_sticky;
               r_state       <= DONE;
            end
            DONE: begin
               r_state <= IDLE;
            end
            default: begin
               r_state <= IDLE;
            end
         endcase
      end
   end

endmodule
